alu_result_buffer: RTL and testbench

- Buffers the 4-bit results produced by the CPU's ALU stage so a slower downstream consumer (display driver or serial sender) can drain them with a valid/ready handshake.
- Sits directly downstream of the ALU: every cycle the ALU flags a result valid, the block captures it into a circular FIFO.
- Reports occupancy, and records when a result was lost because the buffer was full.

---
 rtl/alu_result_buffer.sv | 135 +++++++++++++
 tb/tb_alu_result_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// -----------------
// Circular FIFO that captures every valid ALU result and lets a slower
// downstream consumer drain them with a valid/ready handshake.
//
// Handshake (both sides): a transfer happens on a rising clk edge where the
// producer's valid and the consumer's ready are both 1.  On the input side
// the ALU never waits: y_valid is a one-cycle strobe.  A result that arrives
// while the buffer is full and nothing is popped that cycle is dropped, and
// the drop is recorded.  On the output side out_data/out_valid are held
// stable until out_ready is seen with out_valid=1.
//
// Parameters:
//   DEPTH  number of entries (power of two, 2..16)
//   DW     result width
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset, clears all state
//   y_in       ALU result
//   y_valid    y_in is a new result this cycle
//   out_data   oldest buffered result (head entry)
//   out_valid  out_data holds a valid entry
//   out_ready  consumer accepts out_data this cycle
//   count      number of entries held, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky: at least one result was dropped since reset
//   drop_cnt   (only with ALU_BUF_DROP_CNT_EN) saturating count of drops
//
// Build option: define ALU_BUF_DROP_CNT_EN to add the drop_cnt output;
// overflow is then derived from drop_cnt instead of its own register.

module alu_result_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DW-1:0]          y_in,
    input  logic                   y_valid,
    output logic [DW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
`ifdef ALU_BUF_DROP_CNT_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;

    logic pop;
    logic push;
    logic drop;

    // Status comes straight from the count register, so no input reaches
    // any output combinationally.
    assign full      = (cnt_q == CNT_FULL);
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign out_valid = ~empty;
    assign out_data  = mem[rd_ptr];

    // A pop in the same cycle frees the head slot, so a full buffer can
    // still accept a result when the consumer is draining.
    assign pop  = out_valid & out_ready;
    assign push = y_valid & (~full | pop);
    assign drop = y_valid & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= y_in;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

`ifdef ALU_BUF_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
    assign overflow = (drop_q != 8'd0);
`else
    logic overflow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  localparam int DEPTH = 8;
  localparam int DW    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] y_in;
  logic          y_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef ALU_BUF_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .y_valid   (y_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
`ifdef ALU_BUF_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            drops;
  int            checks;
  int            errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle of the buffer's behaviour, in queue terms.
  task automatic model_step(input logic v, input logic [DW-1:0] y, input logic r);
    int  n;
    bit  pop_ok;
    n      = exp_q.size();
    pop_ok = r && (n > 0);
    if (pop_ok) void'(exp_q.pop_front());
    if (v) begin
      if (n < DEPTH || pop_ok) exp_q.push_back(y);
      else drops++;
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, int'(count), n);
    chk({tag, "_empty"}, int'(empty), int'(n == 0));
    chk({tag, "_full"}, int'(full), int'(n == DEPTH));
    chk({tag, "_out_valid"}, int'(out_valid), int'(n != 0));
    chk({tag, "_overflow"}, int'(overflow), int'(drops > 0));
    if (n > 0) chk({tag, "_out_data"}, int'(out_data), int'(exp_q[0]));
`ifdef ALU_BUF_DROP_CNT_EN
    chk({tag, "_drop_cnt"}, int'(drop_cnt), (drops > 255) ? 255 : drops);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] y,
                       input logic r);
    y_valid   = v;
    y_in      = y;
    out_ready = r;
    model_step(v, y, r);
    @(posedge clk);
    @(negedge clk);
    y_valid   = 1'b0;
    out_ready = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    drops = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] y;
    logic          r;
    int            e_count;
    logic          e_valid;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    checks    = 0;
    errors    = 0;
    drops     = 0;
    y_in      = '0;
    y_valid   = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{1'b1, 4'h3, 1'b0, 1, 1'b1, 4'h3};
    tbl[1] = '{1'b1, 4'hA, 1'b0, 2, 1'b1, 4'h3};
    tbl[2] = '{1'b1, 4'h5, 1'b0, 3, 1'b1, 4'h3};
    tbl[3] = '{1'b0, 4'h0, 1'b1, 2, 1'b1, 4'hA};
    tbl[4] = '{1'b0, 4'h0, 1'b1, 1, 1'b1, 4'h5};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 0, 1'b0, 4'h0};

    // Reset state
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_out_data", int'(out_data), 0);

    // Ordered push then drain
    for (int i = 0; i < 6; i++) begin
      cycle("tbl", tbl[i].v, tbl[i].y, tbl[i].r);
      chk("tbl_count_const", int'(count), tbl[i].e_count);
      chk("tbl_valid_const", int'(out_valid), int'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk("tbl_data_const", int'(out_data), int'(tbl[i].e_data));
    end
    chk("tbl_empty_end", int'(empty), 1);

    // 9 pushes into 8 entries: 9 is lost
    for (int i = 1; i <= 9; i++) cycle("ovf_fill", 1'b1, DW'(i), 1'b0);
    chk("ovf_full", int'(full), 1);
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
`ifdef ALU_BUF_DROP_CNT_EN
    chk("ovf_drop_cnt", int'(drop_cnt), 1);
`endif
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain_data", int'(out_data), i);
      cycle("ovf_drain", 1'b0, '0, 1'b1);
    end
    chk("ovf_drain_empty", int'(empty), 1);
    chk("ovf_sticky", int'(overflow), 1);

    // Asynchronous reset while holding 3 entries
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, DW'(i + 7), 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_out_data", int'(out_data), 0);
    exp_q.delete();
    drops = 0;
    @(negedge clk);
    reset = 1'b1;

    // Full buffer, push and pop together: nothing dropped
    for (int i = 0; i < DEPTH; i++) cycle("sim_fill", 1'b1, DW'($urandom_range(0, 14)), 1'b0);
    cycle("sim_pp", 1'b1, 4'hF, 1'b1);
    chk("sim_count", int'(count), 8);
    chk("sim_overflow", int'(overflow), 0);
    for (int i = 0; i < DEPTH - 1; i++) cycle("sim_drain", 1'b0, '0, 1'b1);
    chk("sim_last_count", int'(count), 1);
    chk("sim_last_data", int'(out_data), 15);
    cycle("sim_drain", 1'b0, '0, 1'b1);

    // Continuous push/pop with one entry in flight
    cycle("stream_prime", 1'b1, 4'h0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cycle("stream", 1'b1, DW'(i % 16), 1'b1);
      chk("stream_count", int'(count), 1);
      chk("stream_data", int'(out_data), i % 16);
    end
    cycle("stream_end", 1'b0, '0, 1'b1);

    // Long run of drops into a full buffer
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle("sat_fill", 1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 300; i++) cycle("sat", 1'b1, DW'($urandom_range(0, 15)), 1'b0);
    chk("sat_overflow", int'(overflow), 1);
`ifdef ALU_BUF_DROP_CNT_EN
    chk("sat_drop_cnt", int'(drop_cnt), 255);
`endif

    // Randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle("rand", 1'($urandom_range(0, 99) < 60), DW'($urandom_range(0, 15)),
            1'($urandom_range(0, 99) < 50));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
